cache_controller: RTL and testbench

Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and `SramController`. Read hits return data in the same cycle with no SRAM access. Misses and all writes are forwarded to the SRAM controller through a registered request/ready handshake. `ready` is low while a transaction is outstanding and is used as the pipeline freeze.

---
 rtl/cache_controller_if.sv | 27 ++
 rtl/cache_controller.sv | 195 +++++++++++++++++++
 tb/tb_cache_controller.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Pipeline-side and SRAM-side signals of the data cache, grouped as one bus.
interface cache_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] ALU_Res;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic        sram_wr_en;
    logic        sram_rd_en;
    logic [31:0] sram_ALU_Res;
    logic [31:0] sram_writeData;
    logic [31:0] sram_readData;
    logic        sram_ready;

    // The cache itself.
    modport slave (
        input  wr_en, rd_en, ALU_Res, writeData, sram_readData, sram_ready,
        output readData, ready, sram_wr_en, sram_rd_en, sram_ALU_Res, sram_writeData
    );

    // The pipeline plus SRAM controller environment around the cache.
    modport master (
        output wr_en, rd_en, ALU_Res, writeData, sram_readData, sram_ready,
        input  readData, ready, sram_wr_en, sram_rd_en, sram_ALU_Res, sram_writeData
    );
endinterface

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Read hits complete combinationally; misses and writes go to the SRAM
// controller through a registered request held until sram_ready.
module cache_controller #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned TAG_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned IDX_LO = 2;
    localparam int unsigned IDX_HI = IDX_LO + IDX_W - 1;
    localparam int unsigned TAG_LO = IDX_HI + 1;
    localparam int unsigned TAG_HI = TAG_LO + TAG_W - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               op_wr_q, op_wr_d;
    logic               sram_rd_en_q, sram_rd_en_d;
    logic               sram_wr_en_q, sram_wr_en_d;

    logic               valid_q [2][SETS];
    logic [TAG_W-1:0]   tag_q   [2][SETS];
    logic [31:0]        data_q  [2][SETS];
    logic               lru_q   [SETS];

    logic [IDX_W-1:0]   req_idx, lat_idx;
    logic [TAG_W-1:0]   req_tag, lat_tag;
    logic               hit0, hit1, hit, hit_way, victim;
    logic [31:0]        hit_data;
    logic               unused_addr_bits;

    // Array write port shared by write hits and miss fills.
    logic               way_we;
    logic               way_sel;
    logic [IDX_W-1:0]   way_idx;
    logic [TAG_W-1:0]   way_tag;
    logic [31:0]        way_data;
    logic               lru_we;
    logic [IDX_W-1:0]   lru_idx;
    logic               lru_val;

    logic               ready_c;
    logic [31:0]        rdata_c;

    assign req_idx  = bus.ALU_Res[IDX_HI:IDX_LO];
    assign req_tag  = bus.ALU_Res[TAG_HI:TAG_LO];
    assign lat_idx  = addr_q[IDX_HI:IDX_LO];
    assign lat_tag  = addr_q[TAG_HI:TAG_LO];
    assign unused_addr_bits = ^{bus.ALU_Res[31:TAG_HI+1], bus.ALU_Res[IDX_LO-1:0]};

    // Lookup of the live pipeline address; fills keep at most one way matching.
    always_comb begin
        hit0     = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
        hit1     = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
        hit      = hit0 || hit1;
        hit_way  = hit1;
        hit_data = hit1 ? data_q[1][req_idx] : data_q[0][req_idx];
    end

    // Victim for the latched miss: first invalid way, else the LRU way.
    always_comb begin
        if (!valid_q[0][lat_idx]) begin
            victim = 1'b0;
        end else if (!valid_q[1][lat_idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[lat_idx];
        end
    end

    // Next state, latch loading, array updates and pipeline-facing outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_wr_d      = op_wr_q;
        sram_rd_en_d = sram_rd_en_q;
        sram_wr_en_d = sram_wr_en_q;
        way_we       = 1'b0;
        way_sel      = 1'b0;
        way_idx      = req_idx;
        way_tag      = req_tag;
        way_data     = bus.writeData;
        lru_we       = 1'b0;
        lru_idx      = req_idx;
        lru_val      = 1'b0;
        ready_c      = 1'b1;
        rdata_c      = 32'h0;

        case (state_q)
            IDLE: begin
                if (bus.wr_en) begin
                    ready_c      = 1'b0;
                    addr_d       = bus.ALU_Res;
                    wdata_d      = bus.writeData;
                    op_wr_d      = 1'b1;
                    sram_wr_en_d = 1'b1;
                    state_d      = ISSUE;
                    if (hit) begin
                        way_we  = 1'b1;
                        way_sel = hit_way;
                        lru_we  = 1'b1;
                        lru_val = ~hit_way;
                    end
                end else if (bus.rd_en) begin
                    if (hit) begin
                        rdata_c = hit_data;
                        lru_we  = 1'b1;
                        lru_val = ~hit_way;
                    end else begin
                        ready_c      = 1'b0;
                        addr_d       = bus.ALU_Res;
                        wdata_d      = bus.writeData;
                        op_wr_d      = 1'b0;
                        sram_rd_en_d = 1'b1;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // sram_ready still reflects the previous transaction here.
                ready_c = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.sram_ready) begin
                    state_d      = IDLE;
                    sram_rd_en_d = 1'b0;
                    sram_wr_en_d = 1'b0;
                    if (!op_wr_q) begin
                        rdata_c  = bus.sram_readData;
                        way_we   = 1'b1;
                        way_sel  = victim;
                        way_idx  = lat_idx;
                        way_tag  = lat_tag;
                        way_data = bus.sram_readData;
                        lru_we   = 1'b1;
                        lru_idx  = lat_idx;
                        lru_val  = ~victim;
                    end
                end else begin
                    ready_c = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latches and cache arrays; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            op_wr_q      <= 1'b0;
            sram_rd_en_q <= 1'b0;
            sram_wr_en_q <= 1'b0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[0][s] <= 1'b0;
                valid_q[1][s] <= 1'b0;
                lru_q[s]      <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_wr_q      <= op_wr_d;
            sram_rd_en_q <= sram_rd_en_d;
            sram_wr_en_q <= sram_wr_en_d;
            if (way_we) begin
                valid_q[way_sel][way_idx] <= 1'b1;
                tag_q[way_sel][way_idx]   <= way_tag;
                data_q[way_sel][way_idx]  <= way_data;
            end
            if (lru_we) begin
                lru_q[lru_idx] <= lru_val;
            end
        end
    end

    assign bus.ready          = rst ? 1'b1  : ready_c;
    assign bus.readData       = rst ? 32'h0 : rdata_c;
    assign bus.sram_rd_en     = sram_rd_en_q & ~rst;
    assign bus.sram_wr_en     = sram_wr_en_q & ~rst;
    assign bus.sram_ALU_Res   = rst ? 32'h0 : addr_q;
    assign bus.sram_writeData = rst ? 32'h0 : wdata_q;
endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller with an SRAM controller model.
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_controller_if bus ();

    cache_controller #(.SETS(64), .TAG_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          is_wr;
        bit          hit;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    bit   mon_skip = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    function automatic logic [31:0] init_word(logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // SRAM controller model: own memory, random latency, sram_ready left stale.
    logic [31:0] sram_mem [logic [29:0]];
    bit          sm_busy;
    int          sm_cnt, sm_lat, sm_pick;
    int          force_lat = 0;
    int          cur_lat   = 0;

    always @(posedge clk) begin
        if (rst) begin
            sm_busy            <= 1'b0;
            bus.sram_ready     <= 1'b0;
            bus.sram_readData  <= 32'h0;
        end else if (bus.sram_rd_en || bus.sram_wr_en) begin
            if (sm_busy && bus.sram_ready) begin
                sm_busy <= 1'b0;
            end else if (!sm_busy) begin
                sm_pick = (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
                cur_lat = sm_pick;
                sm_lat         <= sm_pick;
                sm_busy        <= 1'b1;
                sm_cnt         <= 0;
                bus.sram_ready <= 1'b0;
                if (bus.sram_wr_en) sram_mem[bus.sram_ALU_Res[31:2]] = bus.sram_writeData;
            end else if (sm_cnt + 1 >= sm_lat) begin
                bus.sram_ready    <= 1'b1;
                bus.sram_readData <= sram_mem.exists(bus.sram_ALU_Res[31:2]) ?
                                     sram_mem[bus.sram_ALU_Res[31:2]] :
                                     init_word(bus.sram_ALU_Res[31:2]);
            end else begin
                sm_cnt <= sm_cnt + 1;
            end
        end
    end

    // Reference cache: per-set ways and an LRU bit naming the way to evict next.
    bit          rv [64][2];
    logic [11:0] rt [64][2];
    logic [31:0] rdat [64][2];
    bit          rl [64];
    logic [31:0] ref_mem [logic [29:0]];

    function automatic logic [31:0] ref_word(logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic void ref_clear();
        for (int s = 0; s < 64; s++) begin
            rv[s][0] = 1'b0;
            rv[s][1] = 1'b0;
            rl[s]    = 1'b0;
        end
    endfunction

    task automatic do_op(bit w, bit r, logic [31:0] a, logic [31:0] wd);
        exp_t e;
        int   s   = int'(a[7:2]);
        int   way = -1;
        int   vic;
        int   n   = 0;
        for (int i = 0; i < 2; i++) begin
            if (rv[s][i] && rt[s][i] == a[19:8]) way = i;
        end
        e.is_wr = w;
        e.addr  = a;
        e.wdata = wd;
        e.hit   = (way >= 0) && !w;
        e.data  = 32'h0;
        if (w) begin
            ref_mem[a[31:2]] = wd;
            if (way >= 0) begin
                rdat[s][way] = wd;
                rl[s]        = (way == 0);
            end
        end else if (way >= 0) begin
            e.data = rdat[s][way];
            rl[s]  = (way == 0);
        end else begin
            vic          = !rv[s][0] ? 0 : (!rv[s][1] ? 1 : int'(rl[s]));
            e.data       = ref_word(a[31:2]);
            rv[s][vic]   = 1'b1;
            rt[s][vic]   = a[19:8];
            rdat[s][vic] = e.data;
            rl[s]        = (vic == 0);
        end
        q.push_back(e);
        bus.wr_en     = w;
        bus.rd_en     = r;
        bus.ALU_Res   = a;
        bus.writeData = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready && n < 200);
        if (!bus.ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: ready stuck at 0 for addr 0x%08h", a);
            finish_run();
        end
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    // Monitor: checks SRAM requests every cycle and pops an expectation on each completion.
    int   stalls = 0;
    exp_t mon_e;
    logic [1:0] exp_req;

    always @(negedge clk) begin
        if (rst || mon_skip) begin
            stalls = 0;
        end else begin
            if (bus.sram_rd_en || bus.sram_wr_en) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sram_req: got request with nothing outstanding at %0t", $time);
                end else begin
                    exp_req = q[0].hit ? 2'b00 : (q[0].is_wr ? 2'b10 : 2'b01);
                    check("sram_op", 32'({bus.sram_wr_en, bus.sram_rd_en}), 32'(exp_req));
                    check("sram_addr", bus.sram_ALU_Res, q[0].addr);
                    if (q[0].is_wr) check("sram_wdata", bus.sram_writeData, q[0].wdata);
                end
            end
            if (bus.wr_en || bus.rd_en) begin
                if (bus.ready) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL complete: got completion with nothing outstanding at %0t", $time);
                    end else begin
                        mon_e = q.pop_front();
                        check("stall_cycles", 32'(stalls), mon_e.hit ? 32'd0 : 32'(2 + cur_lat));
                        if (!mon_e.is_wr) check("readData", bus.readData, mon_e.data);
                    end
                    stalls = 0;
                end else begin
                    stalls++;
                end
            end else begin
                stalls = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [11:0] tg;
        logic [5:0]  ix;
        int          kind;

        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.ALU_Res   = 32'h0;
        bus.writeData = 32'h0;
        ref_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_readData", bus.readData, 32'h0);
        check("rst_sram_req", 32'({bus.sram_wr_en, bus.sram_rd_en}), 32'd0);
        check("rst_sram_addr", bus.sram_ALU_Res, 32'h0);
        check("rst_sram_wdata", bus.sram_writeData, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_sram_req", 32'({bus.sram_wr_en, bus.sram_rd_en}), 32'd0);

        // Directed scenarios: cold read, hit, LRU eviction, write hit/miss, write priority.
        sram_mem[30'h100] = 32'hDEADBEEF;
        ref_mem[30'h100]  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        force_lat = 5;
        do_op(1'b0, 1'b1, 32'h400, 32'h0);
        force_lat = 0;
        do_op(1'b0, 1'b1, 32'h400, 32'h0);
        do_op(1'b0, 1'b1, 32'h500, 32'h0);
        do_op(1'b0, 1'b1, 32'h400, 32'h0);
        do_op(1'b0, 1'b1, 32'h600, 32'h0);
        do_op(1'b0, 1'b1, 32'h400, 32'h0);
        do_op(1'b0, 1'b1, 32'h500, 32'h0);
        do_op(1'b1, 1'b0, 32'h400, 32'h12345678);
        do_op(1'b0, 1'b1, 32'h400, 32'h0);
        do_op(1'b1, 1'b0, 32'h700, 32'hCAFEF00D);
        do_op(1'b0, 1'b1, 32'h700, 32'h0);
        do_op(1'b1, 1'b1, 32'h800, 32'hA5A5_0800);
        do_op(1'b0, 1'b1, 32'h800, 32'h0);

        // Random traffic over a few sets and tags so hits, evictions and aliases occur.
        for (int i = 0; i < 400; i++) begin
            r    = $urandom();
            tg   = 12'h100 + 12'($urandom_range(0, 3));
            ix   = 6'($urandom_range(8, 11));
            a    = {r[31:20], tg, ix, r[1:0]};
            kind = int'($urandom_range(0, 9));
            if (kind < 4)       do_op(1'b1, 1'b0, a, $urandom());
            else if (kind == 4) do_op(1'b1, 1'b1, a, $urandom());
            else                do_op(1'b0, 1'b1, a, 32'h0);
            if (r[5:4] == 2'b00) repeat (int'(r[7:6])) @(posedge clk);
            #1;
        end

        // Reset in the middle of a read miss aborts it without filling.
        mon_skip    = 1'b1;
        force_lat   = 5;
        bus.rd_en   = 1'b1;
        bus.ALU_Res = 32'h900;
        repeat (3) @(posedge clk);
        #1;
        check("miss_wait_ready", 32'(bus.ready), 32'd0);
        check("miss_wait_rd_en", 32'(bus.sram_rd_en), 32'd1);
        check("miss_wait_addr", bus.sram_ALU_Res, 32'h900);
        rst       = 1'b1;
        bus.rd_en = 1'b0;
        @(negedge clk);
        check("abort_rst_ready", 32'(bus.ready), 32'd1);
        check("abort_rst_req", 32'({bus.sram_wr_en, bus.sram_rd_en}), 32'd0);
        check("abort_rst_addr", bus.sram_ALU_Res, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_req", 32'({bus.sram_wr_en, bus.sram_rd_en}), 32'd0);
        ref_clear();
        mon_skip  = 1'b0;
        force_lat = 0;
        do_op(1'b0, 1'b1, 32'h900, 32'h0);
        do_op(1'b0, 1'b1, 32'h900, 32'h0);

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        finish_run();
    end
endmodule
